// File: rtl/sfifo_rv_drain_if.sv
// ============================================================================
// Module   : sfifo_rv_drain_if
// Brief    : FIFO read port, flush and valid/ready stream bundle for the drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sfifo_rv_drain_if #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
);
    localparam int LW = $clog2(RD_LAT + 3);

    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [WIDTH-1:0] fifo_rdata;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [LW-1:0]    level;

    // master: the drain stage itself
    modport master (
        input  fifo_rempty, fifo_rdata, flush, m_ready,
        output fifo_rinc, m_valid, m_data, level
    );

    // slave: FIFO plus downstream consumer
    modport slave (
        output fifo_rempty, fifo_rdata, flush, m_ready,
        input  fifo_rinc, m_valid, m_data, level
    );
endinterface

`default_nettype wire

// File: rtl/sfifo_rv_drain.sv
// ============================================================================
// Module   : sfifo_rv_drain
// Brief    : Skid-buffered drain of a synchronous FIFO into a valid/ready stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sfifo_rv_drain #(
    parameter int WIDTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sfifo_rv_drain_if.master   bus
);
    localparam int BUF = RD_LAT + 2;
    localparam int CW  = $clog2(BUF + 1);
    localparam int PW  = $clog2(BUF);
    localparam logic [CW:0]   c_BUF  = (CW+1)'(BUF);
    localparam logic [PW-1:0] c_LAST = PW'(BUF - 1);

    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [WIDTH-1:0] r_mem [BUF];

    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_inflight;
    logic [CW:0]      w_occ;

    // Reads are only issued when a slot is guaranteed for their return.
    assign w_occ   = {1'b0, r_cnt} + {{CW{1'b0}}, w_inflight};
    assign w_issue = rst_n & ~bus.flush & ~bus.fifo_rempty & (w_occ < c_BUF);
    assign w_pop   = (r_cnt != '0) & bus.m_ready;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign w_inflight = 1'b0;
            assign w_push     = w_issue;
        end else begin : g_lat1
            logic r_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= 1'b0;
                end else begin
                    r_pipe <= w_issue;
                end
            end

            // a return landing in the flush cycle is dropped
            assign w_inflight = r_pipe;
            assign w_push     = r_pipe & ~bus.flush;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else if (bus.flush) begin
            r_cnt <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            if (w_push) begin
                r_wp <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_LAST) ? '0 : r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= bus.fifo_rdata;
        end
    end

    assign bus.fifo_rinc = w_issue;
    assign bus.m_valid   = (r_cnt != '0);
    assign bus.m_data    = r_mem[r_rp];
    assign bus.level     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sfifo_rv_drain.sv
// ============================================================================
// Module   : tb_sfifo_rv_drain
// Brief    : Directed bench for sfifo_rv_drain with RD_LAT=1 and RD_LAT=0 instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sfifo_rv_drain;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sfifo_rv_drain_if #(.WIDTH(8), .RD_LAT(1)) b1 ();
    sfifo_rv_drain_if #(.WIDTH(8), .RD_LAT(0)) b0 ();

    sfifo_rv_drain #(.WIDTH(8), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    sfifo_rv_drain #(.WIDTH(8), .RD_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    // FIFO with registered read (RD_LAT=1)
    logic [7:0] mem1 [0:1023];
    int         head1 = 0;
    int         fill1 = 0;
    logic [7:0] rd1;
    assign b1.fifo_rempty = (head1 == fill1);
    assign b1.fifo_rdata  = rd1;
    always @(posedge clk) begin
        if (b1.fifo_rinc) begin
            rd1   <= mem1[head1];
            head1 <= head1 + 1;
        end
    end

    // show-ahead FIFO (RD_LAT=0)
    logic [7:0] mem0 [0:1023];
    int         head0 = 0;
    int         fill0 = 0;
    assign b0.fifo_rempty = (head0 == fill0);
    assign b0.fifo_rdata  = mem0[head0];
    always @(posedge clk) begin
        if (b0.fifo_rinc) head0 <= head0 + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load1(input int first, input int n);
        for (int i = 0; i < n; i++) mem1[head1 + i] = 8'(first + i);
        fill1 = head1 + n;
    endtask

    task automatic load0(input int first, input int n);
        for (int i = 0; i < n; i++) mem0[head0 + i] = 8'(first + i);
        fill0 = head0 + n;
    endtask

    typedef struct {
        bit         load;
        bit         sel0;
        bit         ready;
        bit         flush;
        bit         rinc;
        bit         valid;
        logic [7:0] data;
        int         level;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit ld, input bit s0, input bit rdy, input bit fl,
                       input bit ri, input bit va, input int d, input int lv);
        vec_t v;
        v.load = ld; v.sel0 = s0; v.ready = rdy; v.flush = fl;
        v.rinc = ri; v.valid = va; v.data = 8'(d); v.level = lv;
        vq.push_back(v);
    endtask

    task automatic drain1(input string name);
        int idle;
        idle = 0;
        b1.m_ready = 1'b1;
        for (int i = 0; i < 200 && idle < 3; i++) begin
            @(negedge clk); #1;
            if (b1.fifo_rempty && !b1.m_valid && !b1.fifo_rinc) idle++;
            else idle = 0;
        end
        chk(name, idle >= 3, 1);
    endtask

    initial begin
        int act_rinc, act_valid, act_data, act_level;
        int h, exp_next, seen;
        bit got;

        b1.m_ready = 1'b0; b1.flush = 1'b0;
        b0.m_ready = 1'b0; b0.flush = 1'b0;

        // ---- reset and idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk("idle1_valid", b1.m_valid, 0);
            chk("idle1_rinc", b1.fifo_rinc, 0);
            chk("idle1_level", b1.level, 0);
            chk("idle0_valid", b0.m_valid, 0);
            chk("idle0_level", b0.level, 0);
        end

        // ---- streaming, RD_LAT=1
        add(1,0,1,0, 1,0,0,0);
        add(0,0,1,0, 1,0,0,0);
        for (int k = 2; k <= 15; k++) add(0,0,1,0, 1,1,k-1,1);
        add(0,0,1,0, 0,1,15,1);
        add(0,0,1,0, 0,1,16,1);
        add(0,0,1,0, 0,0,0,0);

        // ---- backpressure, m_ready low in cycles 3..12
        add(1,0,1,0, 1,0,0,0);
        add(0,0,1,0, 1,0,0,0);
        add(0,0,1,0, 1,1,1,1);
        add(0,0,0,0, 1,1,2,1);
        add(0,0,0,0, 0,1,2,2);
        for (int k = 5; k <= 12; k++) add(0,0,0,0, 0,1,2,3);
        add(0,0,1,0, 0,1,2,3);
        add(0,0,1,0, 1,1,3,2);
        for (int k = 15; k <= 25; k++) add(0,0,1,0, 1,1,k-11,1);
        add(0,0,1,0, 0,1,15,1);
        add(0,0,1,0, 0,1,16,1);
        add(0,0,1,0, 0,0,0,0);

        // ---- streaming, RD_LAT=0
        add(1,1,1,0, 1,0,0,0);
        for (int k = 1; k <= 15; k++) add(0,1,1,0, 1,1,k,1);
        add(0,1,1,0, 0,1,16,1);
        add(0,1,1,0, 0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].sel0) begin
                b0.m_ready = vq[i].ready; b0.flush = vq[i].flush;
                if (vq[i].load) load0(1, 16);
            end else begin
                b1.m_ready = vq[i].ready; b1.flush = vq[i].flush;
                if (vq[i].load) load1(1, 16);
            end
            #1;
            if (vq[i].sel0) begin
                act_rinc = b0.fifo_rinc; act_valid = b0.m_valid;
                act_data = b0.m_data;    act_level = b0.level;
            end else begin
                act_rinc = b1.fifo_rinc; act_valid = b1.m_valid;
                act_data = b1.m_data;    act_level = b1.level;
            end
            chk($sformatf("vec%0d_rinc", i), act_rinc, vq[i].rinc);
            chk($sformatf("vec%0d_valid", i), act_valid, vq[i].valid);
            chk($sformatf("vec%0d_level", i), act_level, vq[i].level);
            if (vq[i].valid) chk($sformatf("vec%0d_data", i), act_data, vq[i].data);
        end
        b0.m_ready = 1'b0;

        // ---- flush with a read in flight
        b1.m_ready = 1'b0;
        @(negedge clk); load1(8'hA1, 8); #1;
        chk("fl_c0_rinc", b1.fifo_rinc, 1);
        @(negedge clk); #1;
        chk("fl_c1_rinc", b1.fifo_rinc, 1);
        @(negedge clk); #1;
        chk("fl_c2_rinc", b1.fifo_rinc, 1);
        @(negedge clk); b1.flush = 1'b1; #1;
        chk("fl_F_rinc", b1.fifo_rinc, 0);
        chk("fl_F_level", b1.level, 2);
        chk("fl_F_data", b1.m_data, 8'hA1);
        @(negedge clk); b1.flush = 1'b0; b1.m_ready = 1'b1; #1;
        chk("fl_F1_valid", b1.m_valid, 0);
        chk("fl_F1_level", b1.level, 0);
        chk("fl_F1_rinc", b1.fifo_rinc, 1);
        @(negedge clk); #1;
        chk("fl_F2_valid", b1.m_valid, 0);
        @(negedge clk); #1;
        chk("fl_F3_valid", b1.m_valid, 1);
        chk("fl_F3_data", b1.m_data, 8'hA4);
        drain1("fl_drain");

        // ---- async reset mid-stream
        b1.m_ready = 1'b0;
        @(negedge clk); load1(8'hB1, 8);
        repeat (3) @(negedge clk);
        #1;
        chk("ar_pre_level", b1.level, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", b1.m_valid, 0);
        chk("ar_rinc", b1.fifo_rinc, 0);
        chk("ar_level", b1.level, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b1.m_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (b1.m_valid) got = 1'b1;
        end
        chk("ar_restart_seen", got, 1);
        chk("ar_restart_data", b1.m_data, 8'hB4);
        drain1("ar_drain");

        // ---- RD_LAT=0 under random m_ready
        @(negedge clk); load0(1, 100);
        exp_next = 1;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            if (c > 0) @(negedge clk);
            b0.m_ready = 1'($urandom_range(0, 1));
            #1;
            if (b0.level > 2) begin
                chk("rnd_level_max", b0.level, 2);
            end else begin
                checks++;
            end
            if (b0.m_valid && b0.m_ready) begin
                chk("rnd_data", b0.m_data, 8'(exp_next));
                exp_next++;
                seen++;
            end
        end
        b0.m_ready = 1'b1;
        for (int i = 0; i < 200 && exp_next <= 100; i++) begin
            @(negedge clk); #1;
            if (b0.m_valid) begin
                chk("rnd_tail_data", b0.m_data, 8'(exp_next));
                exp_next++;
            end
        end
        chk("rnd_count", exp_next, 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
